// File: rtl/pp_gen_pipe_pkg.sv
// pp_pkg: shared widths and row type for the partial-product generator
package pp_pkg;
  localparam int OPW = 12;
  localparam int PPW = OPW * OPW;
  typedef logic [OPW-1:0] pp_row_t;
endpackage

// File: rtl/pp_and_array.sv
// pp_and_array: combinational unsigned AND array, row i = a gated by b[i]
module pp_and_array
  import pp_pkg::*;
(
  input  pp_row_t          a,
  input  pp_row_t          b,
  output logic [PPW-1:0]   pp
);
  for (genvar i = 0; i < OPW; i++) begin : g_row
    assign pp[OPW*i +: OPW] = a & {OPW{b[i]}};
  end
endmodule

// File: rtl/pp_gen_pipe.sv
// pp_gen_pipe: two-stage valid/ready partial-product pipeline; PPGEN_SKID_EN adds a registered-ready skid entry
module pp_gen_pipe
  import pp_pkg::*;
#(
  parameter int OPW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       a,
  input  logic [OPW-1:0]       b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPW*OPW-1:0]   pp,
  output logic                 busy
);
  logic           s1_valid_q, s2_valid_q, s1_ld, s2_ld, in_fire, src_valid;
  pp_row_t        a_q, b_q, src_a, src_b;
  logic [PPW-1:0] pp_q, and_pp;
`ifdef PPGEN_SKID_EN
  logic    skid_full_q, skid_full_d;
  pp_row_t skid_a_q, skid_b_q;
  // Stage handshakes; S1 drains the skid entry before taking fresh input
  always_comb begin
    s2_ld       = !s2_valid_q || out_ready;
    s1_ld       = !s1_valid_q || s2_ld;
    in_ready    = rst_n && !skid_full_q;
    in_fire     = in_valid && in_ready;
    src_valid   = skid_full_q || in_fire;
    src_a       = skid_full_q ? skid_a_q : a;
    src_b       = skid_full_q ? skid_b_q : b;
    skid_full_d = src_valid && !s1_ld;
  end
  // Skid entry catches a pair accepted while S1 is blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full_q <= 1'b0;
      skid_a_q    <= '0;
      skid_b_q    <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      if (in_fire && !s1_ld) begin
        skid_a_q <= a;
        skid_b_q <= b;
      end
    end
  end
  assign busy = s1_valid_q || s2_valid_q || skid_full_q;
`else
  // Stage handshakes; ready passes straight back from the output
  always_comb begin
    s2_ld     = !s2_valid_q || out_ready;
    s1_ld     = !s1_valid_q || s2_ld;
    in_ready  = rst_n && s1_ld;
    in_fire   = in_valid && in_ready;
    src_valid = in_fire;
    src_a     = a;
    src_b     = b;
  end
  assign busy = s1_valid_q || s2_valid_q;
`endif
  // S1 operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else if (s1_ld) begin
      s1_valid_q <= src_valid;
      if (src_valid) begin
        a_q <= src_a;
        b_q <= src_b;
      end
    end
  end
  pp_and_array u_and (
    .a  (a_q),
    .b  (b_q),
    .pp (and_pp)
  );
  // S2 partial-product register, fed straight to the compressor tree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      pp_q       <= '0;
    end else if (s2_ld) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) pp_q <= and_pp;
    end
  end
  assign out_valid = s2_valid_q;
  assign pp        = pp_q;
endmodule

// File: doc/pp_gen_pipe.md
PP_GEN_PIPE -- requirements
Module: pp_gen_pipe

Interface
REQ-001 The block SHALL have parameter OPW, default 12, giving the unsigned operand width; only 12 is supported, matching the 12x12 approximate compressor tree.
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair a/b is valid this cycle.
REQ-006 in_ready  output  1  the block accepts an operand pair this cycle.
REQ-007 a  input  OPW  multiplicand, unsigned.
REQ-008 b  input  OPW  multiplier, unsigned.
REQ-009 out_valid  output  1  pp holds a valid partial-product array.
REQ-010 out_ready  input  1  the downstream compressor stage consumes pp this cycle.
REQ-011 pp  output  OPW*OPW  flattened partial products; row i occupies pp[12*i +: 12].
REQ-012 busy  output  1  at least one pipeline stage holds valid data.

Function
REQ-013 A transfer SHALL occur on the input when in_valid and in_ready are both high on a rising clk edge, and on the output when out_valid and out_ready are both high.
REQ-014 Stage S1 SHALL register a and b on each input transfer; stage S2 SHALL register pp[12*i+j] = a[j] & b[i] computed from the S1 operands.
REQ-015 Latency from input transfer to out_valid high SHALL be 2 cycles when the pipeline is empty and out_ready is high.
REQ-016 Throughput SHALL be one transfer per cycle while out_ready stays high.
REQ-017 Each stage SHALL hold a valid flag; a stage SHALL load when it is empty or when its contents move downstream in the same cycle.
REQ-018 The S2 valid flag SHALL drive out_valid directly.
REQ-019 While out_valid is high and out_ready is low, pp SHALL hold stable and no data SHALL be lost or duplicated.
REQ-020 A simultaneous input transfer and output transfer on a full pipeline SHALL advance both stages with no bubble inserted.
REQ-021 Once out_valid is asserted, out_valid SHALL NOT deassert before an output transfer occurs.
REQ-022 Data SHALL leave the block in strict acceptance order.
REQ-023 Operands of zero SHALL produce an all-zero pp and SHALL still produce a transaction.

Reset
REQ-024 On rst_n low, asynchronously: all valid flags SHALL clear, out_valid = 0, busy = 0, and pp and the operand registers SHALL clear to 0.
REQ-025 in_ready SHALL be 0 while rst_n is low, and SHALL be 1 in the first cycle after release.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight transactions, with no output transfer for them after release.

Configuration
REQ-027 The block SHALL support macro PPGEN_SKID_EN.
REQ-028 With PPGEN_SKID_EN defined, the block SHALL add a one-entry skid register ahead of S1 and SHALL drive in_ready from a flop: in_ready = !skid_full.
  - Accepted data SHALL go to the skid register when S1 cannot load.
  - Latency SHALL be unchanged when the skid register is empty.
  - Exactly one extra pair SHALL be absorbed after out_ready drops.
REQ-029 Without PPGEN_SKID_EN, in_ready SHALL be combinational: in_ready = !s1_valid || s1 advances this cycle.

Structure
REQ-030 A shared package pp_pkg SHALL hold localparam OPW = 12, localparam PPW = OPW*OPW, and typedef pp_row_t (OPW bits).
REQ-031 The block SHALL contain one sub-module, pp_and_array: purely combinational, OPW a/b in, PPW pp out; the same module serves a future signed/Booth variant.
REQ-032 The registered pp output SHALL connect unmodified to the pp input of the downstream compressor tree.

Verification
REQ-033 Bench scenario, basic: a=12'hFFF, b=12'hFFF, out_ready=1 -> out_valid high 2 cycles after transfer, pp = all 144 ones.
REQ-034 Bench scenario, single bit: a=12'h001, b=12'h800 -> only pp[132] = 1; a=12'h800, b=12'h001 -> only pp[11] = 1.
REQ-035 Bench scenario, backpressure: stream 4 pairs (a=1..4, b=12'h003), hold out_ready=0 for 5 cycles, then release -> outputs in order, pp stable while stalled, in_ready low once full, no loss.
REQ-036 Bench scenario, full-rate: 100 random pairs with out_ready=1 and in_valid=1 -> 100 outputs on consecutive cycles, each matching a golden AND array.
REQ-037 Bench scenario, reset mid-operation: 2 pairs in flight, pulse rst_n low for 1 cycle -> out_valid=0, busy=0, no stale outputs after release.
REQ-038 Bench scenario, with PPGEN_SKID_EN: drop out_ready while in_valid stays high -> exactly one extra pair accepted after the drop, in_ready low the following cycle, all pairs delivered after release.
